// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data memory and its lane logic.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    typedef enum logic {
        SZ_WORD = 1'b0,
        SZ_BYTE = 1'b1
    } dmem_size_t;

    function automatic logic is_misaligned(input dmem_size_t size, input logic [1:0] a1_0);
        return (size == SZ_WORD) && (a1_0 != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: merges a store into the old word and extracts load data.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wd,
    input  logic [1:0]  i_lane,
    input  dmem_size_t  i_size,
    output logic [31:0] o_store_word,
    output logic [31:0] o_load_data
);

    always_comb begin
        o_store_word = i_wd;
        o_load_data  = i_old_word;
        if (i_size == SZ_BYTE) begin
            o_store_word = i_old_word;
            case (i_lane)
                2'd0: begin
                    o_store_word[7:0]   = i_wd[7:0];
                    o_load_data         = {24'b0, i_old_word[7:0]};
                end
                2'd1: begin
                    o_store_word[15:8]  = i_wd[7:0];
                    o_load_data         = {24'b0, i_old_word[15:8]};
                end
                2'd2: begin
                    o_store_word[23:16] = i_wd[7:0];
                    o_load_data         = {24'b0, i_old_word[23:16]};
                end
                default: begin
                    o_store_word[31:24] = i_wd[7:0];
                    o_load_data         = {24'b0, i_old_word[31:24]};
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_wait.sv
// Data memory with req/ready handshake, configurable wait states, byte/word access and error reporting.
//   state | meaning
//   IDLE  | waiting for req; accepts and latches the access
//   WAIT  | counting down wait states; inputs ignored
//   DONE  | one-cycle ready pulse, rd/err valid
module dmem_wait
    import dmem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 64,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        size,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]  r_mem [DEPTH_WORDS];

    dmem_state_t  r_state, w_state_nxt;
    logic [3:0]   r_cnt, w_cnt_nxt;
    logic         r_we;
    dmem_size_t   r_size;
    logic [31:0]  r_a;
    logic [31:0]  r_wd;
    logic [31:0]  r_rd;
    logic         r_err;

    logic         w_accept;
    logic         w_commit;
    logic         w_src_we;
    dmem_size_t   w_src_size;
    logic [31:0]  w_src_a;
    logic [31:0]  w_src_wd;
    logic [AW-1:0] w_word_idx;
    logic         w_oob;
    logic         w_err;
    logic         w_wr_en;
    logic [31:0]  w_old_word;
    logic [31:0]  w_store_word;
    logic [31:0]  w_load_data;

    assign w_accept = (r_state == IDLE) && req;
    // With no wait states the accept edge is also the commit edge, so the live inputs are used.
    assign w_commit = ((r_state == WAIT) && (r_cnt == 4'd0)) || ((WAIT_STATES == 0) && w_accept);

    assign w_src_we   = (r_state == IDLE) ? we                : r_we;
    assign w_src_size = (r_state == IDLE) ? dmem_size_t'(size) : r_size;
    assign w_src_a    = (r_state == IDLE) ? a                 : r_a;
    assign w_src_wd   = (r_state == IDLE) ? wd                : r_wd;

    assign w_word_idx = w_src_a[AW+1:2];
    assign w_oob      = |w_src_a[31:AW+2];
    assign w_err      = w_oob || is_misaligned(w_src_size, w_src_a[1:0]);
    assign w_old_word = r_mem[w_word_idx];
    assign w_wr_en    = reset && w_commit && w_src_we && !w_err;

    dmem_lane u_lane (
        .i_old_word   (w_old_word),
        .i_wd         (w_src_wd),
        .i_lane       (w_src_a[1:0]),
        .i_size       (w_src_size),
        .o_store_word (w_store_word),
        .o_load_data  (w_load_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) w_state_nxt = DONE;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_size  <= SZ_WORD;
            r_a     <= 32'd0;
            r_wd    <= 32'd0;
            r_rd    <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we   <= we;
                r_size <= dmem_size_t'(size);
                r_a    <= a;
                r_wd   <= wd;
            end
            if (w_commit) begin
                r_err <= w_err;
                if (w_err)          r_rd <= 32'd0;
                else if (!w_src_we) r_rd <= w_load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[w_word_idx] <= w_store_word;
    end

    assign rd    = r_rd;
    assign ready = (r_state == DONE);
    assign busy  = (r_state != IDLE);
    assign err   = r_err && ready;

endmodule

// File: tb/tb_dmem_wait.sv
// Self-checking bench for dmem_wait: three instances (2, 0 and 3 wait states) against a word-array model.
module tb_dmem_wait;

    logic        clk;
    logic        reset;
    logic        req   [3];
    logic        we    [3];
    logic        size  [3];
    logic [31:0] a     [3];
    logic [31:0] wd    [3];
    logic [31:0] rd    [3];
    logic        ready [3];
    logic        err   [3];
    logic        busy  [3];

    logic [31:0] mem_m [3][64];
    logic [31:0] rd_m  [3];
    int n_vec;
    int n_miss;

    dmem_wait #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_dut_ws2 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .size(size[0]), .a(a[0]), .wd(wd[0]),
        .rd(rd[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0]));
    dmem_wait #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .size(size[1]), .a(a[1]), .wd(wd[1]),
        .rd(rd[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1]));
    dmem_wait #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u_dut_ws3 (
        .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .size(size[2]), .a(a[2]), .wd(wd[2]),
        .rd(rd[2]), .ready(ready[2]), .err(err[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int d);
        if (d == 0) return 2;
        if (d == 1) return 0;
        return 3;
    endfunction

    // Runs one access on instance d and checks latency, pulse shape, err and rd against the model.
    task automatic do_txn(input int d, input bit w, input bit sz, input logic [31:0] addr,
                          input logic [31:0] data, input bit scramble);
        int lat;
        bit e;
        int sh;
        int idx;
        logic [31:0] old;
        logic [31:0] exp_rd;
        e   = (sz == 1'b0 && addr[1:0] != 2'b00) || ((addr / 4) >= 64);
        idx = int'(addr[7:2]);
        sh  = 8 * int'(addr[1:0]);
        old = mem_m[d][idx];
        if (e) begin
            exp_rd = 32'd0;
        end else if (w) begin
            exp_rd = rd_m[d];
            if (sz) mem_m[d][idx] = (old & ~(32'hFF << sh)) | ({24'd0, data[7:0]} << sh);
            else    mem_m[d][idx] = data;
        end else begin
            exp_rd = sz ? ((old >> sh) & 32'hFF) : old;
        end
        rd_m[d] = exp_rd;

        @(negedge clk);
        req[d] = 1'b1; we[d] = w; size[d] = sz; a[d] = addr; wd[d] = data;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (scramble) begin
                a[d] = $urandom; wd[d] = $urandom; we[d] = 1'($urandom); size[d] = 1'($urandom);
            end
            if (ready[d]) break;
            n_vec++;
            if (busy[d] !== 1'b1) begin
                n_miss++;
                $display("FAIL busy_wait dut%0d: got %b want 1", d, busy[d]);
            end
        end
        n_vec++;
        if (ready[d] !== 1'b1 || lat != ws_of(d) + 1) begin
            n_miss++;
            $display("FAIL latency dut%0d addr=%h: ready=%b after %0d edges want %0d", d, addr, ready[d], lat, ws_of(d) + 1);
        end
        n_vec++;
        if (err[d] !== e) begin
            n_miss++;
            $display("FAIL err dut%0d addr=%h sz=%0d: got %b want %b", d, addr, sz, err[d], e);
        end
        n_vec++;
        if (rd[d] !== exp_rd) begin
            n_miss++;
            $display("FAIL rd dut%0d addr=%h we=%0d sz=%0d: got %h want %h", d, addr, w, sz, rd[d], exp_rd);
        end
        req[d] = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (ready[d] !== 1'b0 || busy[d] !== 1'b0) begin
            n_miss++;
            $display("FAIL pulse_end dut%0d: ready=%b busy=%b want 0 0", d, ready[d], busy[d]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; size[d] = 1'b0; a[d] = 32'd0; wd[d] = 32'd0; rd_m[d] = 32'd0;
        end
        #12;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (rd[d] !== 32'd0 || ready[d] !== 1'b0 || err[d] !== 1'b0 || busy[d] !== 1'b0) begin
                n_miss++;
                $display("FAIL reset dut%0d: rd=%h ready=%b err=%b busy=%b want all 0", d, rd[d], ready[d], err[d], busy[d]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 64; i++)
                do_txn(d, 1'b1, 1'b0, 32'(i * 4), $urandom, 1'b0);
    endtask

    task automatic test_directed();
        do_txn(0, 1'b1, 1'b0, 32'h64, 32'd7, 1'b0);
        do_txn(0, 1'b0, 1'b0, 32'h64, 32'd0, 1'b0);
        n_vec++;
        if (rd[0] !== 32'h7) begin
            n_miss++;
            $display("FAIL load_0x64: got %h want 00000007", rd[0]);
        end
        do_txn(0, 1'b1, 1'b0, 32'h60, 32'h11223344, 1'b0);
        do_txn(0, 1'b1, 1'b1, 32'h61, 32'h000000AB, 1'b0);
        do_txn(0, 1'b0, 1'b0, 32'h60, 32'd0, 1'b0);
        n_vec++;
        if (rd[0] !== 32'h1122AB44) begin
            n_miss++;
            $display("FAIL byte_merge: got %h want 1122ab44", rd[0]);
        end
        do_txn(0, 1'b0, 1'b1, 32'h63, 32'd0, 1'b0);
        n_vec++;
        if (rd[0] !== 32'h11) begin
            n_miss++;
            $display("FAIL byte_load: got %h want 00000011", rd[0]);
        end
        do_txn(0, 1'b0, 1'b0, 32'h62, 32'd0, 1'b0);
        do_txn(0, 1'b0, 1'b0, 32'h60, 32'd0, 1'b0);
        do_txn(0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0);
        do_txn(0, 1'b0, 1'b0, 32'h000, 32'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; size[0] = 1'b0; a[0] = 32'h64; wd[0] = 32'h55;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        n_vec++;
        if (ready[0] !== 1'b0 || err[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_miss++;
            $display("FAIL async_reset: ready=%b err=%b busy=%b want 0 0 0", ready[0], err[0], busy[0]);
        end
        req[0] = 1'b0;
        for (int d = 0; d < 3; d++) rd_m[d] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        do_txn(0, 1'b0, 1'b0, 32'h64, 32'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit exp_pulse;
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; size[1] = 1'b0; a[1] = 32'h10; wd[1] = 32'd0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            exp_pulse = (i % 2) == 0;
            n_vec++;
            if (ready[1] !== exp_pulse || busy[1] !== exp_pulse) begin
                n_miss++;
                $display("FAIL b2b edge%0d: ready=%b busy=%b want %b", i, ready[1], busy[1], exp_pulse);
            end
            if (exp_pulse) begin
                n_vec++;
                if (rd[1] !== mem_m[1][4]) begin
                    n_miss++;
                    $display("FAIL b2b_rd edge%0d: got %h want %h", i, rd[1], mem_m[1][4]);
                end
            end
        end
        req[1] = 1'b0;
        rd_m[1] = mem_m[1][4];
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int k;
        bit w;
        bit sz;
        logic [31:0] addr;
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                k  = $urandom_range(0, 9);
                w  = 1'($urandom);
                sz = 1'($urandom);
                addr = {24'd0, 8'($urandom)};
                if (k <= 4)      addr[1:0] = sz ? addr[1:0] : 2'b00;
                else if (k == 5) begin sz = 1'b0; addr[1:0] = 2'($urandom_range(1, 3)); end
                else if (k <= 7) addr = $urandom | 32'h100;
                else             sz = 1'b1;
                do_txn(d, w, sz, addr, $urandom, d == 2 || n % 2 == 1);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        test_reset();
        test_fill();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
